// File: rtl/wb_stage.sv
// Writeback retire buffer: saturates lanes, queues writes, retires them in order to the register file.
// Latency: minimum 1 cycle from push to rf_we; the head entry is driven combinationally from storage.
// Backpressure: wb_stall when full; a push while full without a pop is dropped and sets sticky ovf.
// Optional operand forwarding ports are enabled by defining WB_FORWARD_EN.
module wb_stage #(
    parameter int DataWidth    = 32,
    parameter int TotalNumBank = 8,
    parameter int AddrWidth    = 5,
    parameter int FifoDepth    = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    des_sat_w,
    input  logic [3:0]              des_mask_w,
    input  logic [TotalNumBank-1:0] writeEn_w,
    input  logic [AddrWidth-1:0]    writeAddr_w,
    input  logic [DataWidth-1:0]    res0_w,
    input  logic [DataWidth-1:0]    res1_w,
    input  logic [DataWidth-1:0]    res2_w,
    input  logic [DataWidth-1:0]    res3_w,
    input  logic [19:0]             flags_w,
    input  logic                    rf_ready,
    input  logic                    flags_clr,
    output logic [TotalNumBank-1:0] rf_we,
    output logic [AddrWidth-1:0]    rf_addr,
    output logic [4*DataWidth-1:0]  rf_data,
    output logic [3:0]              rf_mask,
    output logic                    wb_stall,
    output logic [19:0]             flags_q,
    output logic                    ovf
`ifdef WB_FORWARD_EN
    ,
    output logic                    fwd_valid,
    output logic [AddrWidth-1:0]    fwd_addr,
    output logic [4*DataWidth-1:0]  fwd_data
`endif
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    typedef struct packed {
        logic [TotalNumBank-1:0] we;
        logic [AddrWidth-1:0]    addr;
        logic [3:0]              mask;
        logic [4*DataWidth-1:0]  data;
        logic [19:0]             flags;
    } entry_t;

    entry_t          mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] cnt;

    logic   in_vld;
    logic   full;
    logic   has_head;
    logic   pop;
    logic   push;
    entry_t in_ent;
    entry_t head;

    // Lanes are signed; saturation only clamps negatives to zero.
    function automatic logic [DataWidth-1:0] sat_lane(input logic [DataWidth-1:0] v,
                                                      input logic en);
        return (en && v[DataWidth-1]) ? '0 : v;
    endfunction

    always_comb begin
        in_vld       = |writeEn_w;
        full         = (cnt == CntW'(FifoDepth));
        has_head     = (cnt != '0);
        pop          = has_head && rf_ready;
        push         = in_vld && (!full || pop);
        in_ent.we    = writeEn_w;
        in_ent.addr  = writeAddr_w;
        in_ent.mask  = des_mask_w;
        in_ent.data  = {sat_lane(res3_w, des_sat_w), sat_lane(res2_w, des_sat_w),
                        sat_lane(res1_w, des_sat_w), sat_lane(res0_w, des_sat_w)};
        in_ent.flags = flags_w;
        head         = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            flags_q <= '0;
            ovf     <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_ent;
                wr_ptr      <= wr_ptr + PtrW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PtrW'(1);
            if (push && !pop)      cnt <= cnt + CntW'(1);
            else if (pop && !push) cnt <= cnt - CntW'(1);
            if (in_vld && full && !pop) ovf <= 1'b1;
            // A clear coinciding with a pop keeps only the retiring entry's flags.
            if (pop)            flags_q <= flags_clr ? head.flags : (flags_q | head.flags);
            else if (flags_clr) flags_q <= '0;
        end
    end

    // Zero-mask entries still retire but never strobe the register file.
    always_comb begin
        rf_we    = (has_head && (head.mask != 4'h0)) ? head.we : '0;
        rf_addr  = has_head ? head.addr : '0;
        rf_data  = has_head ? head.data : '0;
        rf_mask  = has_head ? head.mask : '0;
        wb_stall = full;
    end

`ifdef WB_FORWARD_EN
    entry_t youngest;

    // An entry being pushed this cycle is newer than anything stored.
    always_comb begin
        youngest  = mem[wr_ptr - PtrW'(1)];
        fwd_valid = push || has_head;
        fwd_addr  = '0;
        fwd_data  = '0;
        if (push) begin
            fwd_addr = in_ent.addr;
            fwd_data = in_ent.data;
        end else if (has_head) begin
            fwd_addr = youngest.addr;
            fwd_data = youngest.data;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: queue-based reference model plus directed scenarios.
module tb_wb_stage;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         des_sat_w = 1'b0;
    logic [3:0]   des_mask_w = '0;
    logic [7:0]   writeEn_w = '0;
    logic [4:0]   writeAddr_w = '0;
    logic [31:0]  res0_w = '0, res1_w = '0, res2_w = '0, res3_w = '0;
    logic [19:0]  flags_w = '0;
    logic         rf_ready = 1'b0;
    logic         flags_clr = 1'b0;
    logic [7:0]   rf_we;
    logic [4:0]   rf_addr;
    logic [127:0] rf_data;
    logic [3:0]   rf_mask;
    logic         wb_stall;
    logic [19:0]  flags_q;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk(clk), .rstn(rstn), .des_sat_w(des_sat_w), .des_mask_w(des_mask_w),
        .writeEn_w(writeEn_w), .writeAddr_w(writeAddr_w),
        .res0_w(res0_w), .res1_w(res1_w), .res2_w(res2_w), .res3_w(res3_w),
        .flags_w(flags_w), .rf_ready(rf_ready), .flags_clr(flags_clr),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_mask(rf_mask),
        .wb_stall(wb_stall), .flags_q(flags_q), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   we;
        logic [4:0]   addr;
        logic [3:0]   mask;
        logic [127:0] data;
        logic [19:0]  flags;
    } ment_t;

    ment_t       mq[$];
    logic [19:0] m_flags = '0;
    logic        m_ovf = 1'b0;

    function automatic logic [31:0] sat(input logic [31:0] v, input logic en);
        if (en && ($signed(v) < 0)) return 32'h0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: retire queue of at most 4 entries, updated on each rising edge.
    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            mq.delete();
            m_flags = '0;
            m_ovf   = 1'b0;
        end else begin
            bit    do_pop;
            bit    was_full;
            ment_t e;
            do_pop   = (mq.size() > 0) && rf_ready;
            was_full = (mq.size() == 4);
            if (do_pop) begin
                e = mq.pop_front();
                m_flags = flags_clr ? e.flags : (m_flags | e.flags);
            end else if (flags_clr) begin
                m_flags = '0;
            end
            if (writeEn_w != 0) begin
                if (!was_full || do_pop) begin
                    e.we    = writeEn_w;
                    e.addr  = writeAddr_w;
                    e.mask  = des_mask_w;
                    e.data  = {sat(res3_w, des_sat_w), sat(res2_w, des_sat_w),
                               sat(res1_w, des_sat_w), sat(res0_w, des_sat_w)};
                    e.flags = flags_w;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Compare every cycle, away from the rising edge.
    initial forever begin
        logic [7:0]   e_we;
        logic [4:0]   e_addr;
        logic [127:0] e_data;
        logic [3:0]   e_mask;
        @(negedge clk);
        e_we = '0; e_addr = '0; e_data = '0; e_mask = '0;
        if (mq.size() > 0) begin
            e_we   = (mq[0].mask == 4'h0) ? 8'h0 : mq[0].we;
            e_addr = mq[0].addr;
            e_data = mq[0].data;
            e_mask = mq[0].mask;
        end
        chk("model_rf_we", rf_we, e_we);
        chk("model_rf_addr", rf_addr, e_addr);
        chk("model_rf_data", rf_data, e_data);
        chk("model_rf_mask", rf_mask, e_mask);
        chk("model_wb_stall", wb_stall, mq.size() == 4);
        chk("model_flags_q", flags_q, m_flags);
        chk("model_ovf", ovf, m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] we, input logic [4:0] addr, input logic [3:0] mask,
                         input logic sat_en, input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3, input logic [19:0] fl);
        writeEn_w = we; writeAddr_w = addr; des_mask_w = mask; des_sat_w = sat_en;
        res0_w = r0; res1_w = r1; res2_w = r2; res3_w = r3; flags_w = fl;
    endtask

    task automatic idle();
        drive(8'h0, 5'h0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 20'h0);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_stall", wb_stall, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_flags", flags_q, 0);
        rstn = 1'b1;
        tick();

        // Single write, one-cycle latency
        rf_ready = 1'b1;
        drive(8'h01, 5'd3, 4'hF, 1'b0, 32'd5, 32'h0, 32'h0, 32'h0, 20'h0);
        chk("single_not_early", rf_we, 0);
        tick();
        idle();
        chk("single_we", rf_we, 8'h01);
        chk("single_addr", rf_addr, 5'd3);
        chk("single_lane0", rf_data[31:0], 32'd5);
        tick();
        chk("single_drained", rf_we, 0);

        // Saturation on and off
        rf_ready = 1'b0;
        drive(8'h02, 5'd4, 4'hF, 1'b1, 32'h0, 32'hFFFF_FFF0, 32'd7, 32'h0, 20'h0);
        tick();
        drive(8'h02, 5'd5, 4'hF, 1'b0, 32'h0, 32'hFFFF_FFF0, 32'd7, 32'h0, 20'h0);
        tick();
        idle();
        chk("sat_lane1", rf_data[63:32], 32'h0);
        chk("sat_lane2", rf_data[95:64], 32'd7);
        rf_ready = 1'b1;
        tick();
        chk("nosat_lane1", rf_data[63:32], 32'hFFFF_FFF0);
        tick();
        chk("sat_drained", rf_we, 0);

        // Full with simultaneous push and pop
        rf_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'h01, 5'(i), 4'hF, 1'b0, 32'(i), 32'h0, 32'h0, 32'h0, 20'h0);
            tick();
        end
        chk("pp_full", wb_stall, 1);
        rf_ready = 1'b1;
        drive(8'h01, 5'd9, 4'hF, 1'b0, 32'h9, 32'h0, 32'h0, 32'h0, 20'h0);
        tick();
        idle();
        rf_ready = 1'b0;
        chk("pp_no_ovf", ovf, 0);
        chk("pp_still_full", wb_stall, 1);
        rf_ready = 1'b1;
        repeat (4) tick();
        chk("pp_drained", wb_stall, 0);

        // Zero-mask entry and sticky flags
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        rf_ready = 1'b0;
        drive(8'h04, 5'd7, 4'h0, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 20'h00010);
        tick();
        idle();
        chk("zmask_we", rf_we, 0);
        chk("zmask_addr", rf_addr, 5'd7);
        rf_ready = 1'b1;
        tick();
        chk("zmask_flags", flags_q, 20'h00010);
        rf_ready = 1'b0;
        drive(8'h01, 5'd8, 4'hF, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 20'h00003);
        tick();
        idle();
        chk("flags_hold", flags_q, 20'h00010);
        flags_clr = 1'b1;
        rf_ready  = 1'b1;
        tick();
        chk("flags_clr_pop", flags_q, 20'h00003);
        rf_ready = 1'b0;
        tick();
        flags_clr = 1'b0;
        chk("flags_clr", flags_q, 20'h0);

        // Backpressure, drop, in-order drain
        for (int i = 0; i < 4; i++) begin
            drive(8'(1 << i), 5'(10 + i), 4'hF, 1'b0, 32'(100 + i), 32'h0, 32'h0, 32'h0, 20'h0);
            tick();
        end
        chk("bp_stall", wb_stall, 1);
        chk("bp_no_ovf_yet", ovf, 0);
        drive(8'h80, 5'd20, 4'hF, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0, 20'h0);
        tick();
        idle();
        chk("bp_ovf", ovf, 1);
        rf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_order_addr", rf_addr, 5'(10 + i));
            chk("bp_order_we", rf_we, 8'(1 << i));
            tick();
        end
        chk("bp_drained", rf_we, 0);
        chk("bp_ovf_sticky", ovf, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) < 6)
                drive(8'($urandom), 5'($urandom),
                      ($urandom_range(0, 6) == 0) ? 4'h0 : 4'($urandom),
                      1'($urandom), $urandom, $urandom, $urandom, $urandom, 20'($urandom));
            else
                idle();
            rf_ready  = (c < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            flags_clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle();
        flags_clr = 1'b0;
        rf_ready  = 1'b1;
        repeat (6) tick();

        // Reset in the middle of draining
        rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 5'(i + 1), 4'hF, 1'b0, 32'hA, 32'hB, 32'hC, 32'hD, 20'hFFFFF);
            tick();
        end
        idle();
        rf_ready = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_rf_mask", rf_mask, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_flags", flags_q, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) tick();
        rstn = 1'b1;
        chk("post_rst_we0", rf_we, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_write", rf_we, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
